// File: rtl/scr_base_l3_pkg.sv
// scr_base_l3_pkg: shared L3 retry types (cause, per-cell state, cell index)
package scr_base_l3_pkg;
  localparam int L3_ROB_DEPTH = 16;
  typedef enum logic {ADDR_CONFLICT, RES_FULL} l3_retry_cause_e;
  typedef enum logic [1:0] {IDLE, WAIT, READY, OUT} l3_retry_state_e;
  typedef logic [$clog2(L3_ROB_DEPTH)-1:0] l3_cell_idx_t;
endpackage

// File: rtl/scr_base_l3_rr_pick.sv
// scr_base_l3_rr_pick: N-way round-robin picker, first request at or above ptr_i with wraparound
//   in : req_i request vector, ptr_i search start
//   out: gnt_o one-hot grant, idx_o encoded winner, any_o any request present
module scr_base_l3_rr_pick #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] j;
  always_comb begin
    j = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr_i + W'(k);
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/scr_base_l3_bk_rob_retry.sv
// scr_base_l3_bk_rob_retry: L3 bank ROB retry scheduler, parks nacked cells until wake-up or timeout and replays them round-robin
//   in : tp_nack_* nack capture, wake_addr_* / wake_res_i wake-up events, rob_retry_rdy_i arbiter accept
//   out: rob_retry_* valid/ready retry payload, retry_pend_o cells not idle, retry_err_o nack to a busy cell
module scr_base_l3_bk_rob_retry
  import scr_base_l3_pkg::*;
#(
  parameter int ROB_DEPTH = L3_ROB_DEPTH,
  parameter int ADDR_W = 40,
  parameter int OPC_W = 5,
  parameter int WAIT_TMO = 255,
  localparam int CW = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tp_nack_val_i,
  input  logic [CW-1:0]     tp_nack_cell_i,
  input  logic              tp_nack_cause_i,
  input  logic [OPC_W-1:0]  tp_nack_opc_i,
  input  logic [ADDR_W-1:0] tp_nack_addr_i,
  input  logic              wake_addr_val_i,
  input  logic [ADDR_W-1:0] wake_addr_i,
  input  logic              wake_res_i,
  input  logic              rob_retry_rdy_i,
  output logic              rob_retry_val_o,
  output logic [CW-1:0]     rob_retry_cell_o,
  output logic [OPC_W-1:0]  rob_retry_opc_o,
  output logic [ADDR_W-1:0] rob_retry_addr_o,
  output logic [CW:0]       retry_pend_o,
  output logic              retry_err_o
);
  l3_retry_state_e st_q [ROB_DEPTH], st_d [ROB_DEPTH];
  l3_retry_cause_e cause_q [ROB_DEPTH], cause_d [ROB_DEPTH];
  logic [OPC_W-1:0] copc_q [ROB_DEPTH], copc_d [ROB_DEPTH];
  logic [ADDR_W-1:0] caddr_q [ROB_DEPTH], caddr_d [ROB_DEPTH];
  logic [7:0] cnt_q [ROB_DEPTH], cnt_d [ROB_DEPTH];
  logic [CW-1:0] ptr_q, ptr_d, cell_q, cell_d, pk_idx;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW:0] pend_q, pend_d;
  logic [ROB_DEPTH-1:0] req, pk_gnt;
  logic val_q, val_d, err_q, err_d, pk_any, pick, acc, nk_wake;
  l3_retry_cause_e nk_cause;
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_req
    assign req[i] = st_q[i] == READY;
  end
  scr_base_l3_rr_pick #(.N(ROB_DEPTH)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pk_gnt),
    .idx_o(pk_idx),
    .any_o(pk_any)
  );
  assign pick = !val_q || rob_retry_rdy_i;
  assign acc = val_q && rob_retry_rdy_i;
  assign nk_cause = l3_retry_cause_e'(tp_nack_cause_i);
  // a wake-up coinciding with the nack itself must not be lost
  assign nk_wake = nk_cause == RES_FULL ? wake_res_i : wake_addr_val_i && wake_addr_i == tp_nack_addr_i;
  assign val_d = pick ? pk_any : val_q;
  assign cell_d = pick && pk_any ? pk_idx : cell_q;
  assign opc_d = pick && pk_any ? copc_q[pk_idx] : opc_q;
  assign addr_d = pick && pk_any ? caddr_q[pk_idx] : addr_q;
  assign ptr_d = pick && pk_any ? pk_idx + 1'b1 : ptr_q;
  always_comb begin
    st_d = st_q;
    cause_d = cause_q;
    copc_d = copc_q;
    caddr_d = caddr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    pend_d = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (st_q[i] == WAIT) begin
        cnt_d[i] = cnt_q[i] + {7'd0, cnt_q[i] != 8'hff};
        // the incremented count is compared so READY lands WAIT_TMO cycles after entering WAIT
        if ((cause_q[i] == RES_FULL ? wake_res_i : wake_addr_val_i && wake_addr_i == caddr_q[i]) ||
            (WAIT_TMO != 0 && cnt_d[i] == 8'(WAIT_TMO)))
          st_d[i] = READY;
      end
      if (pick && pk_gnt[i]) st_d[i] = OUT;
    end
    if (acc) st_d[cell_q] = IDLE;
    if (tp_nack_val_i && st_q[tp_nack_cell_i] != IDLE) err_d = 1'b1;
    else if (tp_nack_val_i) begin
      st_d[tp_nack_cell_i] = nk_wake ? READY : WAIT;
      cause_d[tp_nack_cell_i] = nk_cause;
      copc_d[tp_nack_cell_i] = tp_nack_opc_i;
      caddr_d[tp_nack_cell_i] = tp_nack_addr_i;
      cnt_d[tp_nack_cell_i] = '0;
    end
    for (int i = 0; i < ROB_DEPTH; i++) pend_d = pend_d + (CW+1)'(st_d[i] != IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= '{default: IDLE};
      cause_q <= '{default: ADDR_CONFLICT};
      copc_q <= '{default: '0};
      caddr_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ptr_q <= '0;
      val_q <= 1'b0;
      cell_q <= '0;
      opc_q <= '0;
      addr_q <= '0;
      pend_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cause_q <= cause_d;
      copc_q <= copc_d;
      caddr_q <= caddr_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      val_q <= val_d;
      cell_q <= cell_d;
      opc_q <= opc_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign rob_retry_val_o = val_q;
  assign rob_retry_cell_o = cell_q;
  assign rob_retry_opc_o = opc_q;
  assign rob_retry_addr_o = addr_q;
  assign retry_pend_o = pend_q;
  assign retry_err_o = err_q;
endmodule

// File: tb/tb_scr_base_l3_bk_rob_retry.sv
// tb_scr_base_l3_bk_rob_retry: directed table, corner sequences and random run against a cycle-level reference model
module tb_scr_base_l3_bk_rob_retry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nv = 1'b0, ncause = 1'b0, wv = 1'b0, wr = 1'b0, rdy = 1'b0;
  logic [3:0] ncell = '0;
  logic [4:0] nopc = '0;
  logic [39:0] naddr = '0, waddr = '0;
  logic v4, e4, v0, e0;
  logic [3:0] c4, c0;
  logic [4:0] o4, o0, p4, p0;
  logic [39:0] a4, a0;
  int pass = 0, total = 0, cyc = 0;
  bit men = 1'b0;

  always #5 clk = ~clk;

  scr_base_l3_bk_rob_retry #(.ROB_DEPTH(16), .ADDR_W(40), .OPC_W(5), .WAIT_TMO(4)) d4 (
    .clk(clk), .rst_n(rst_n),
    .tp_nack_val_i(nv), .tp_nack_cell_i(ncell), .tp_nack_cause_i(ncause),
    .tp_nack_opc_i(nopc), .tp_nack_addr_i(naddr),
    .wake_addr_val_i(wv), .wake_addr_i(waddr), .wake_res_i(wr),
    .rob_retry_rdy_i(rdy), .rob_retry_val_o(v4), .rob_retry_cell_o(c4),
    .rob_retry_opc_o(o4), .rob_retry_addr_o(a4), .retry_pend_o(p4), .retry_err_o(e4)
  );
  scr_base_l3_bk_rob_retry #(.ROB_DEPTH(16), .ADDR_W(40), .OPC_W(5), .WAIT_TMO(0)) d0 (
    .clk(clk), .rst_n(rst_n),
    .tp_nack_val_i(nv), .tp_nack_cell_i(ncell), .tp_nack_cause_i(ncause),
    .tp_nack_opc_i(nopc), .tp_nack_addr_i(naddr),
    .wake_addr_val_i(wv), .wake_addr_i(waddr), .wake_res_i(wr),
    .rob_retry_rdy_i(rdy), .rob_retry_val_o(v0), .rob_retry_cell_o(c0),
    .rob_retry_opc_o(o0), .rob_retry_addr_o(a0), .retry_pend_o(p0), .retry_err_o(e0)
  );

  localparam int FREE = 0, PARK = 1, RDYC = 2, SENT = 3;
  typedef struct {int ph; bit cause; int since; logic [4:0] opc; logic [39:0] addr;} mcell_t;
  mcell_t mc [2][16];
  bit mval [2], merr [2];
  int mcell [2], mptr [2], mpend [2];
  logic [4:0] mopc [2];
  logic [39:0] maddr [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else pass++;
  endtask

  function automatic bit woke(input bit cause, input logic [39:0] a);
    return cause ? wr : (wv && waddr == a);
  endfunction

  // one clock of the retry rules: wake/timeout, accept, round-robin pick, nack capture
  task automatic mstep(input int m, input int tmo);
    mcell_t nx [16];
    int w, cl;
    bit can;
    for (int i = 0; i < 16; i++) nx[i] = mc[m][i];
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) nx[i].ph = FREE;
      mval[m] = 0; mcell[m] = 0; mopc[m] = 0; maddr[m] = 0; mptr[m] = 0; merr[m] = 0;
    end else begin
      can = !mval[m] || rdy;
      for (int i = 0; i < 16; i++)
        if (mc[m][i].ph == PARK && (woke(mc[m][i].cause, mc[m][i].addr) || (tmo != 0 && cyc == mc[m][i].since + tmo)))
          nx[i].ph = RDYC;
      if (mval[m] && rdy) nx[mcell[m]].ph = FREE;
      w = -1;
      for (int k = 0; k < 16; k++) begin
        cl = (mptr[m] + k) % 16;
        if (can && w < 0 && mc[m][cl].ph == RDYC) w = cl;
      end
      if (can) mval[m] = (w >= 0);
      if (w >= 0) begin
        nx[w].ph = SENT;
        mcell[m] = w; mopc[m] = mc[m][w].opc; maddr[m] = mc[m][w].addr; mptr[m] = (w + 1) % 16;
      end
      merr[m] = nv && mc[m][ncell].ph != FREE;
      if (nv && mc[m][ncell].ph == FREE) nx[ncell] = '{woke(ncause, naddr) ? RDYC : PARK, ncause, cyc, nopc, naddr};
    end
    mpend[m] = 0;
    for (int i = 0; i < 16; i++) begin
      mc[m][i] = nx[i];
      if (nx[i].ph != FREE) mpend[m]++;
    end
  endtask

  task automatic mcmp(input int m, input logic v, input logic [3:0] c, input logic [4:0] o,
                      input logic [39:0] a, input logic [4:0] p, input logic e);
    string s;
    s = m == 0 ? "m4" : "m0";
    chk({s, "_val"}, v, mval[m]);
    if (mval[m]) begin
      chk({s, "_cell"}, c, mcell[m]);
      chk({s, "_opc"}, o, mopc[m]);
      chk({s, "_addr"}, a, maddr[m]);
    end
    chk({s, "_pend"}, p, mpend[m]);
    chk({s, "_err"}, e, merr[m]);
  endtask

  task automatic tick();
    mstep(0, 4);
    mstep(1, 0);
    cyc++;
    @(posedge clk);
    #1;
    if (men) begin
      mcmp(0, v4, c4, o4, a4, p4, e4);
      mcmp(1, v0, c0, o0, a0, p0, e0);
    end
  endtask

  task automatic idle_in();
    nv = 0; ncell = 0; ncause = 0; nopc = 0; naddr = 0; wv = 0; waddr = 0; wr = 0;
  endtask

  task automatic collect(input int e [3], input int n, input string nm);
    int got [$];
    for (int c = 0; c < 8; c++) begin
      tick();
      if (v4) got.push_back(int'(c4));
    end
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", nm, i), i < got.size() ? got[i] : -1, e[i]);
  endtask

  typedef struct {
    bit nv; int ncell; bit ncause; logic [39:0] naddr; bit wv; logic [39:0] waddr; bit wr; bit rdy;
    bit ev; int ec; logic [39:0] ea; int ep; bit ee;
  } vec_t;
  vec_t tv [18];
  logic [39:0] pool [4];

  initial begin
    tv[0]  = '{1, 3, 0, 40'h100, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 1, 0};
    tv[2]  = '{0, 0, 0, 0, 1, 40'h100, 0, 0,   0, 0, 0, 1, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 3, 40'h100, 1, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 3, 40'h100, 1, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 3, 40'h100, 1, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 3, 40'h100, 1, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0, 0, 0};
    tv[8]  = '{1, 7, 0, 40'h240, 1, 40'h240, 0, 0, 0, 0, 0, 1, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 7, 40'h240, 1, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0, 0, 0};
    tv[11] = '{1, 2, 1, 40'h300, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 1, 0};
    tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 1, 0};
    tv[14] = '{1, 2, 0, 40'h380, 0, 0, 0, 0,   0, 0, 0, 1, 1};
    tv[15] = '{0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 1, 0};
    tv[16] = '{0, 0, 0, 0, 0, 0, 0, 0,         1, 2, 40'h300, 1, 0};
    tv[17] = '{0, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0, 0, 0};
    pool = '{40'h100, 40'h140, 40'h240, 40'h300};
    idle_in();
    tick();
    tick();
    chk("rst_val", v4, 0);
    chk("rst_cell", c4, 0);
    chk("rst_addr", a4, 0);
    chk("rst_pend", p4, 0);
    chk("rst_err", e4, 0);
    rst_n = 1;
    men = 1;
    for (int i = 0; i < 18; i++) begin
      nv = tv[i].nv; ncell = 4'(tv[i].ncell); ncause = tv[i].ncause; nopc = 5'(i + 1); naddr = tv[i].naddr;
      wv = tv[i].wv; waddr = tv[i].waddr; wr = tv[i].wr; rdy = tv[i].rdy;
      tick();
      chk($sformatf("tbl%0d_val", i), v4, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("tbl%0d_cell", i), c4, tv[i].ec);
        chk($sformatf("tbl%0d_addr", i), a4, tv[i].ea);
      end
      chk($sformatf("tbl%0d_pend", i), p4, tv[i].ep);
      chk($sformatf("tbl%0d_err", i), e4, tv[i].ee);
    end
    idle_in();
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("notmo_val", v0, 0);
    end
    chk("notmo_pend", p0, 1);
    nv = 1; ncell = 9; ncause = 1; nopc = 5'h1f; naddr = 40'h440; wr = 1;
    tick();
    idle_in();
    tick();
    chk("hs_val", v4, 1);
    chk("hs_cell", c4, 9);
    rst_n = 0;
    tick();
    chk("mrst_val", v4, 0);
    chk("mrst_cell", c4, 0);
    chk("mrst_opc", o4, 0);
    chk("mrst_addr", a4, 0);
    chk("mrst_pend", p4, 0);
    chk("mrst_err", e4, 0);
    chk("mrst_val0", v0, 0);
    chk("mrst_pend0", p0, 0);
    rst_n = 1;
    rdy = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_val", v4, 0);
      chk("post_rst_pend", p4, 0);
    end
    nv = 1; ncause = 1; naddr = 40'h500;
    ncell = 1; tick();
    ncell = 5; tick();
    ncell = 14; tick();
    idle_in();
    wr = 1; tick();
    wr = 0;
    collect('{1, 5, 14}, 3, "rr1");
    nv = 1; ncause = 1; naddr = 40'h600;
    ncell = 0; tick();
    ncell = 2; tick();
    idle_in();
    wr = 1; tick();
    wr = 0;
    collect('{0, 2, 0}, 2, "rr2");
    for (int c = 0; c < 3000; c++) begin
      nv = ($urandom_range(0, 1) == 1);
      ncell = 4'($urandom_range(0, 15));
      ncause = 1'($urandom_range(0, 1));
      nopc = 5'($urandom);
      naddr = pool[$urandom_range(0, 3)];
      wv = ($urandom_range(0, 3) == 0);
      waddr = pool[$urandom_range(0, 3)];
      wr = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
